// File: rtl/audio_sample_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_stream_pkg                                             |
// | Description : Shared types and constants for the audio sample streamer.    |
// |               Holds the bus FSM state encoding, the audio-core register    |
// |               offsets, the byte-enable mask and a small min helper.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package audio_stream_pkg;

    // Bus sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_SPACE = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WR_L     = 3'd3,
        ST_WR_R     = 3'd4
    } state_t;

    // Audio core register offsets relative to its base address.
    localparam logic [31:0] c_OFS_FIFOSPACE = 32'd4;
    localparam logic [31:0] c_OFS_LEFTDATA  = 32'd8;
    localparam logic [31:0] c_OFS_RIGHTDATA = 32'd12;

    // Every transfer is a full 32-bit word.
    localparam logic [3:0]  c_BYTE_EN_ALL   = 4'b1111;

    function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_sample_streamer_if                                     |
// | Description : Bundles the solver sample stream, the Avalon master bus and  |
// |               the status outputs of the streamer.                          |
// |   master : the streamer (drives sample_ready/req, bus strobes, status)     |
// |   slave  : the environment (solver + audio core)                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface audio_sample_streamer_if #(
    parameter int SAMPLE_W = 18
);
    logic                enable;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic                sample_req;
    logic [31:0]         bus_addr;
    logic [3:0]          bus_byte_enable;
    logic                bus_read;
    logic                bus_write;
    logic [31:0]         bus_write_data;
    logic                bus_ack;
    logic [31:0]         bus_read_data;
    logic [7:0]          fifo_space;
    logic [15:0]         underrun_count;
    logic [15:0]         timeout_count;

    modport master (
        input  enable, sample_in, sample_valid, bus_ack, bus_read_data,
        output sample_ready, sample_req, bus_addr, bus_byte_enable,
               bus_read, bus_write, bus_write_data,
               fifo_space, underrun_count, timeout_count
    );

    modport slave (
        output enable, sample_in, sample_valid, bus_ack, bus_read_data,
        input  sample_ready, sample_req, bus_addr, bus_byte_enable,
               bus_read, bus_write, bus_write_data,
               fifo_space, underrun_count, timeout_count
    );

endinterface
`default_nettype wire

// File: rtl/audio_sample_streamer_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_fifo                                                  |
// | Description : Small synchronous FIFO for solver samples. Head word is      |
// |               visible on o_dout without a pop (show-ahead).                |
// |   clk, rst         : clock, async active-high reset                        |
// |   i_push / i_din   : write request and data (ignored when full)            |
// |   i_pop            : drop head word (ignored when empty)                   |
// |   o_dout           : head word                                             |
// |   o_count          : stored words, 0..DEPTH                                |
// |   o_full / o_empty : occupancy flags                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sample_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic [W-1:0]           i_din,
    output wire logic [W-1:0]           o_dout,
    output wire logic [$clog2(DEPTH):0] o_count,
    output wire logic                   o_full,
    output wire logic                   o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_full    = (r_count == (c_AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/audio_sample_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_sample_streamer                                        |
// | Description : Buffers signed solver samples and streams each one to the    |
// |               left and right channels of the Avalon audio core, after      |
// |               polling the core's free space. Requests the next sample from |
// |               the solver and keeps underrun / bus-timeout counters.        |
// |   clk, rst : clock, async active-high reset                                |
// |   io_bus   : sample stream, Avalon master signals and status outputs       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module audio_sample_streamer #(
    parameter int          SAMPLE_W    = 18,
    parameter int          SHIFT       = 14,
    parameter logic [31:0] AUDIO_BASE  = 32'h0000_3040,
    parameter int          SPACE_MIN   = 3,
    parameter int          BUF_DEPTH   = 4,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    audio_sample_streamer_if.master io_bus
);
    import audio_stream_pkg::*;

    localparam int                c_TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_TMR_W-1:0]         r_timer;
    logic [7:0]                 r_fifo_space;
    logic [15:0]                r_underrun;
    logic [15:0]                r_timeout;
    logic                       r_req_flag;
    logic                       r_sample_req;

    logic                       w_push;
    logic                       w_pop;
    logic [SAMPLE_W-1:0]        w_head;
    logic [$clog2(BUF_DEPTH):0] w_count;
    logic                       w_full;
    logic                       w_empty;

    logic                       w_tmo;
    logic                       w_space_ld;
    logic                       w_inc_underrun;
    logic                       w_inc_timeout;
    logic                       w_req_cond;
    logic [31:0]                w_ext;
    logic [31:0]                w_word;

    logic                       w_bus_read;
    logic                       w_bus_write;
    logic [31:0]                w_bus_addr;
    logic [3:0]                 w_bus_be;
    logic [31:0]                w_bus_wdata;

    // Only the two space bytes of the FIFOSPACE register matter here.
    logic [15:0]                w_unused_rdata;
    assign w_unused_rdata = io_bus.bus_read_data[15:0];

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    assign w_push = io_bus.sample_valid & ~w_full;

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (io_bus.sample_in),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sign-extend to 32 bits, then scale into the audio word.
    assign w_ext  = {{(32-SAMPLE_W){w_head[SAMPLE_W-1]}}, w_head};
    assign w_word = w_ext << SHIFT;

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    assign w_tmo = (r_timer == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Timer restarts on every state entry; it stops at the limit so
            // a long IDLE cannot wrap it.
            if (w_state_nxt != r_state) r_timer <= '0;
            else if (!w_tmo)            r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_space_ld     = 1'b0;
        w_inc_underrun = 1'b0;
        w_inc_timeout  = 1'b0;
        w_bus_read     = 1'b0;
        w_bus_write    = 1'b0;
        w_bus_addr     = '0;
        w_bus_be       = '0;
        w_bus_wdata    = '0;

        case (r_state)
            ST_IDLE: begin
                if (io_bus.enable) w_state_nxt = ST_RD_SPACE;
            end

            ST_RD_SPACE: begin
                w_bus_read = 1'b1;
                w_bus_addr = AUDIO_BASE + c_OFS_FIFOSPACE;
                w_bus_be   = c_BYTE_EN_ALL;
                if (io_bus.bus_ack) begin
                    w_space_ld  = 1'b1;
                    w_state_nxt = ST_CHECK;
                end else if (w_tmo) begin
                    w_inc_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                if (r_fifo_space >= 8'(SPACE_MIN)) begin
                    if (!w_empty) w_state_nxt    = ST_WR_L;
                    else          w_inc_underrun = 1'b1;
                end
            end

            ST_WR_L: begin
                w_bus_write = 1'b1;
                w_bus_addr  = AUDIO_BASE + c_OFS_LEFTDATA;
                w_bus_be    = c_BYTE_EN_ALL;
                w_bus_wdata = w_word;
                if (io_bus.bus_ack) begin
                    w_state_nxt = ST_WR_R;
                end else if (w_tmo) begin
                    w_inc_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_WR_R: begin
                w_bus_write = 1'b1;
                w_bus_addr  = AUDIO_BASE + c_OFS_RIGHTDATA;
                w_bus_be    = c_BYTE_EN_ALL;
                w_bus_wdata = w_word;
                // Sample leaves the buffer only once both channels took it;
                // a timeout keeps it for the retry.
                if (io_bus.bus_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_inc_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_space <= '0;
            r_underrun   <= '0;
            r_timeout    <= '0;
        end else begin
            if (w_space_ld)
                r_fifo_space <= min_u8(io_bus.bus_read_data[31:24],
                                       io_bus.bus_read_data[23:16]);
            if (w_inc_underrun && (r_underrun != 16'hFFFF))
                r_underrun <= r_underrun + 16'd1;
            if (w_inc_timeout && (r_timeout != 16'hFFFF))
                r_timeout <= r_timeout + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next-sample request: at most one outstanding, cleared by the push
    // that answers it.
    // ------------------------------------------------------------------
    assign w_req_cond = io_bus.enable & ~r_req_flag &
                        (((32'(w_count) + 32'd1) < 32'(BUF_DEPTH)) |
                         ((w_count == '0) & w_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_flag   <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_sample_req <= w_req_cond;
            if (w_req_cond)  r_req_flag <= 1'b1;
            else if (w_push) r_req_flag <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_bus.sample_ready    = ~w_full;
    assign io_bus.sample_req      = r_sample_req;
    assign io_bus.bus_addr        = w_bus_addr;
    assign io_bus.bus_byte_enable = w_bus_be;
    assign io_bus.bus_read        = w_bus_read;
    assign io_bus.bus_write       = w_bus_write;
    assign io_bus.bus_write_data  = w_bus_wdata;
    assign io_bus.fifo_space      = r_fifo_space;
    assign io_bus.underrun_count  = r_underrun;
    assign io_bus.timeout_count   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_audio_sample_streamer                                     |
// | Description : Directed self-checking bench for audio_sample_streamer with  |
// |               a small Avalon slave model that acks after two cycles.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_audio_sample_streamer;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // Slave model state and bus observations.
    int          ack_cnt;
    bit          withhold_wrl;
    int          req_pulses;
    int          wr_cycles;
    int          rd_acks;
    int          be_err;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    audio_sample_streamer_if #(.SAMPLE_W(18)) bif ();

    audio_sample_streamer #(
        .SAMPLE_W    (18),
        .SHIFT       (14),
        .AUDIO_BASE  (32'h0000_3040),
        .SPACE_MIN   (3),
        .BUF_DEPTH   (4),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Avalon slave: ack two cycles after a strobe appears, one-cycle ack.
    always @(negedge clk) begin
        if (rst) begin
            bif.bus_ack = 1'b0;
            ack_cnt     = 0;
        end else begin
            if (bif.sample_req) req_pulses++;
            if (bif.bus_write)  wr_cycles++;
            if ((bif.bus_read || bif.bus_write) && (bif.bus_byte_enable !== 4'hF)) be_err++;
            if (bif.bus_ack) begin
                bif.bus_ack = 1'b0;
                ack_cnt     = 0;
            end else if ((bif.bus_read || bif.bus_write) &&
                         !(withhold_wrl && bif.bus_write && bif.bus_addr == 32'h3048)) begin
                ack_cnt++;
                if (ack_cnt >= 2) begin
                    bif.bus_ack = 1'b1;
                    ack_cnt     = 0;
                    if (bif.bus_write) begin
                        log_addr.push_back(bif.bus_addr);
                        log_data.push_back(bif.bus_write_data);
                    end else begin
                        rd_acks++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst              = 1'b1;
        bif.enable       = 1'b0;
        bif.sample_valid = 1'b0;
        bif.sample_in    = '0;
        withhold_wrl     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic push(input logic [17:0] v);
        int t;
        t = 0;
        @(negedge clk);
        while (!bif.sample_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bif.sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: sample_ready=%b required 1", bif.sample_ready);
        end
        bif.sample_in    = v;
        bif.sample_valid = 1'b1;
        @(negedge clk);
        bif.sample_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int limit);
        int t;
        t = 0;
        while (log_addr.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (log_addr.size() < n) begin
            errors++;
            $display("FAIL wait_writes: got %0d writes required %0d", log_addr.size(), n);
        end
    endtask

    task automatic check_pair(input string name, input logic [31:0] data);
        checks++;
        if (log_addr.size() < 2) begin
            errors++;
            $display("FAIL %s_count: got %0d writes required 2", name, log_addr.size());
        end else begin
            if (log_addr[0] !== 32'h3048 || log_data[0] !== data) begin
                errors++;
                $display("FAIL %s_left: addr=%h data=%h required 00003048 %h",
                         name, log_addr[0], log_data[0], data);
            end
            checks++;
            if (log_addr[1] !== 32'h304C || log_data[1] !== data) begin
                errors++;
                $display("FAIL %s_right: addr=%h data=%h required 0000304c %h",
                         name, log_addr[1], log_data[1], data);
            end
        end
    endtask

    // Waits for one more underrun, proving the buffer is empty again.
    task automatic expect_underrun(input string name);
        logic [15:0] u0;
        int t;
        u0 = bif.underrun_count;
        t  = 0;
        while (bif.underrun_count == u0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bif.underrun_count !== u0 + 16'd1) begin
            errors++;
            $display("FAIL %s_underrun: underrun_count=%0d required %0d",
                     name, bif.underrun_count, u0 + 16'd1);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bif.enable       = 1'b0;
        bif.sample_valid = 1'b0;
        bif.sample_in    = '0;
        bif.bus_read_data = '0;
        withhold_wrl     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.sample_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b required 1", bif.sample_ready);
        end
        checks++;
        if ({bif.sample_req, bif.bus_read, bif.bus_write} !== 3'b000) begin
            errors++; $display("FAIL rst_strobes: req/rd/wr=%b required 000",
                               {bif.sample_req, bif.bus_read, bif.bus_write});
        end
        checks++;
        if (bif.bus_addr !== 32'h0 || bif.bus_byte_enable !== 4'h0 || bif.bus_write_data !== 32'h0) begin
            errors++; $display("FAIL rst_bus: addr=%h be=%h wd=%h required 0",
                               bif.bus_addr, bif.bus_byte_enable, bif.bus_write_data);
        end
        checks++;
        if (bif.fifo_space !== 8'h0 || bif.underrun_count !== 16'h0 || bif.timeout_count !== 16'h0) begin
            errors++; $display("FAIL rst_status: space=%h und=%h tmo=%h required 0",
                               bif.fifo_space, bif.underrun_count, bif.timeout_count);
        end
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_basic();
        bif.bus_read_data = 32'h7F7F_0000;
        bif.enable        = 1'b1;
        push(18'h00888);
        wait_writes(2, 300);
        check_pair("basic", 32'h0222_0000);
        checks++;
        if (bif.fifo_space !== 8'h7F) begin
            errors++; $display("FAIL basic_space: got %h required 7f", bif.fifo_space);
        end
        expect_underrun("basic");
        checks++;
        if (log_addr.size() != 2) begin
            errors++; $display("FAIL basic_single_pop: got %0d writes required 2", log_addr.size());
        end
    endtask

    task automatic test_negative();
        log_addr.delete();
        log_data.delete();
        push(18'h3FFFF);
        wait_writes(2, 300);
        check_pair("negative", 32'hFFFF_C000);
    endtask

    task automatic test_backpressure();
        int r0;
        bif.bus_read_data = 32'h4002_0000;
        repeat (20) @(negedge clk);
        log_addr.delete();
        log_data.delete();
        r0 = rd_acks;
        push(18'h00100);
        repeat (100) @(negedge clk);
        checks++;
        if (log_addr.size() != 0) begin
            errors++; $display("FAIL bp_nowrite: got %0d writes required 0", log_addr.size());
        end
        checks++;
        if (rd_acks - r0 < 3) begin
            errors++; $display("FAIL bp_polls: got %0d polls required >=3", rd_acks - r0);
        end
        checks++;
        if (bif.fifo_space !== 8'h02) begin
            errors++; $display("FAIL bp_space: got %h required 02", bif.fifo_space);
        end
        bif.bus_read_data = 32'h4040_0000;
        wait_writes(2, 300);
        check_pair("bp_resume", 32'h0040_0000);
        checks++;
        if (bif.fifo_space !== 8'h40) begin
            errors++; $display("FAIL bp_space2: got %h required 40", bif.fifo_space);
        end
    endtask

    task automatic test_underrun();
        int r0, w0, q0;
        do_reset();
        bif.bus_read_data = 32'h7F7F_0000;
        r0 = rd_acks;
        w0 = wr_cycles;
        q0 = req_pulses;
        bif.enable = 1'b1;
        repeat (200) @(negedge clk);
        bif.enable = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (rd_acks - r0 < 5 || int'(bif.underrun_count) != rd_acks - r0) begin
            errors++; $display("FAIL und_count: underrun_count=%0d required %0d (>=5)",
                               bif.underrun_count, rd_acks - r0);
        end
        checks++;
        if (wr_cycles != w0) begin
            errors++; $display("FAIL und_nowrite: got %0d write cycles required 0", wr_cycles - w0);
        end
        checks++;
        if (req_pulses - q0 != 1) begin
            errors++; $display("FAIL und_req_once: got %0d pulses required 1", req_pulses - q0);
        end
        bif.enable = 1'b1;
        push(18'h00200);
        wait_writes(2, 300);
        check_pair("und_push", 32'h0080_0000);
        checks++;
        if (req_pulses - q0 != 2) begin
            errors++; $display("FAIL und_req_rearm: got %0d pulses required 2", req_pulses - q0);
        end
    endtask

    task automatic test_timeout();
        int t, n;
        bif.bus_read_data = 32'h7F7F_0000;
        bif.enable        = 1'b1;
        withhold_wrl      = 1'b1;
        repeat (20) @(negedge clk);
        log_addr.delete();
        log_data.delete();
        push(18'h00001);
        t = 0;
        while (!(bif.bus_write && bif.bus_addr == 32'h3048) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (bif.bus_write && n < 1100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 1024) begin
            errors++; $display("FAIL tmo_length: strobe held %0d cycles required 1024", n);
        end
        checks++;
        if (bif.timeout_count !== 16'd1) begin
            errors++; $display("FAIL tmo_count: got %0d required 1", bif.timeout_count);
        end
        withhold_wrl = 1'b0;
        wait_writes(2, 300);
        check_pair("tmo_retry", 32'h0000_4000);
        expect_underrun("tmo");
        checks++;
        if (log_addr.size() != 2 || bif.timeout_count !== 16'd1) begin
            errors++; $display("FAIL tmo_after: writes=%0d tmo=%0d required 2 1",
                               log_addr.size(), bif.timeout_count);
        end
    endtask

    task automatic test_async_reset();
        int t;
        bif.enable = 1'b0;
        repeat (20) @(negedge clk);
        bif.bus_read_data = 32'h7F7F_0000;
        push(18'h00010);
        push(18'h00020);
        push(18'h00030);
        bif.enable = 1'b1;
        t = 0;
        while (!(bif.bus_write && bif.bus_addr == 32'h304C) && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(bif.bus_write && bif.bus_addr == 32'h304C)) begin
            errors++; $display("FAIL ar_reach_wrr: addr=%h wr=%b required 0000304c 1",
                               bif.bus_addr, bif.bus_write);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bif.bus_write !== 1'b0 || bif.bus_read !== 1'b0 || bif.bus_addr !== 32'h0) begin
            errors++; $display("FAIL ar_strobes: wr=%b rd=%b addr=%h required 0 0 0",
                               bif.bus_write, bif.bus_read, bif.bus_addr);
        end
        checks++;
        if (bif.sample_ready !== 1'b1 || bif.underrun_count !== 16'h0 ||
            bif.timeout_count !== 16'h0 || bif.fifo_space !== 8'h0) begin
            errors++; $display("FAIL ar_status: ready=%b und=%0d tmo=%0d space=%h required 1 0 0 00",
                               bif.sample_ready, bif.underrun_count, bif.timeout_count, bif.fifo_space);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
        t = 0;
        while (!(bif.bus_read || bif.bus_write) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bif.bus_read !== 1'b1 || bif.bus_write !== 1'b0 || bif.bus_addr !== 32'h3044) begin
            errors++; $display("FAIL ar_first_read: rd=%b wr=%b addr=%h required 1 0 00003044",
                               bif.bus_read, bif.bus_write, bif.bus_addr);
        end
        expect_underrun("ar_empty");
        checks++;
        if (log_addr.size() != 0) begin
            errors++; $display("FAIL ar_nowrite: got %0d writes required 0", log_addr.size());
        end
        checks++;
        if (be_err != 0) begin
            errors++; $display("FAIL byte_enable: %0d strobe cycles without 4'hf", be_err);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        ack_cnt      = 0;
        req_pulses   = 0;
        wr_cycles    = 0;
        rd_acks      = 0;
        be_err       = 0;
        withhold_wrl = 1'b0;
        bif.bus_ack  = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_underrun();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_sample_streamer.md
Name: audio_sample_streamer

Overview:
- Downstream stage of the drum solver (`square`): accepts signed node samples and buffers them in a small FIFO.
- Acts as Avalon bus master to the audio core. It polls the core's FIFO space, then writes each sample to the left and right channels.
- Pulses a next-sample request back to the solver, replacing the ad-hoc bus FSM in the top level.
- Adds left/right space checking, a bus-ack timeout and status counters.

Parameters:
- SAMPLE_W, 18, width of the signed solver sample.
- SHIFT, 14, left shift applied to the sign-extended sample to form the 32-bit audio word.
- AUDIO_BASE, 32'h00003040, Avalon base address of the audio core.
- SPACE_MIN, 3, minimum free words required in both channels before writing.
- BUF_DEPTH, 4, sample buffer depth; power of two, at least 2.
- TIMEOUT_CYC, 1024, cycles to wait for bus_ack before aborting a transaction.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous active-high reset.
- enable  in  1  streaming enable.
- sample_in  in  SAMPLE_W  signed sample from the solver.
- sample_valid  in  1  sample_in valid; accepted when sample_ready=1.
- sample_ready  out  1  buffer not full.
- sample_req  out  1  one-cycle pulse asking the solver for the next sample (the solver's shoot input).
- bus_addr  out  32  Avalon address.
- bus_byte_enable  out  4  byte mask, always 4'b1111 during a transaction.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_write_data  out  32  write data.
- bus_ack  in  1  Avalon acknowledge.
- bus_read_data  in  32  Avalon read data.
- fifo_space  out  8  last sampled min(WSLC, WSRC).
- underrun_count  out  16  saturating count of underrun events.
- timeout_count  out  16  saturating count of bus timeouts.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; FSM in IDLE; buffer empty; request flag clear; counters 0.
  - Exception: sample_ready is 1 after reset, because the buffer is empty.
- Sample buffer (sample_fifo):
  - sample_ready = (count < BUF_DEPTH), from registered count.
  - Push on sample_valid & sample_ready. Pop on WR_R ack.
  - A simultaneous push and pop leaves count unchanged.
  - Pushing while full is impossible, since ready=0.
- Request flag:
  - sample_req pulses for one cycle when enable=1, the request flag is clear, and (count + 1) < BUF_DEPTH or count==0 with a pop this cycle. The pulse sets the flag.
  - The flag clears on the next accepted push.
  - Never more than one outstanding request.
- FSM states: IDLE, RD_SPACE, CHECK, WR_L, WR_R. Each strobe is asserted from state entry until the cycle bus_ack=1, then dropped on the next edge.
  - IDLE: strobes 0. If enable=1, go to RD_SPACE next cycle. This gives at least one idle cycle between transactions.
  - RD_SPACE: bus_read=1, bus_addr=AUDIO_BASE+4. On ack, fifo_space <= min(bus_read_data[31:24], bus_read_data[23:16]), then go to CHECK.
  - CHECK: one cycle, no strobe.
    - fifo_space >= SPACE_MIN and buffer non-empty: go to WR_L.
    - fifo_space >= SPACE_MIN and buffer empty: underrun_count++, go to IDLE.
    - Otherwise: go to IDLE.
  - WR_L: bus_write=1, addr AUDIO_BASE+8, data = {sign-extend(head) to 32} << SHIFT, truncated to 32 bits. On ack, go to WR_R.
  - WR_R: same data, addr AUDIO_BASE+12. On ack, pop the buffer and go to IDLE.
- Timeout:
  - A per-transaction counter resets on state entry.
  - If it reaches TIMEOUT_CYC-1 without ack: drop the strobe, timeout_count++, go to IDLE without popping.
  - The same sample is retried from RD_SPACE, so a left-channel duplicate is acceptable.
- enable deasserted mid-transaction: the current bus transaction completes (or times out), then the FSM holds IDLE. sample_req is suppressed; pushes are still accepted.
- Counters saturate at 16'hFFFF.
- bus_ack outside RD_SPACE, WR_L or WR_R is ignored.

Decomposition:
- Package audio_stream_pkg:
  - FSM state enum.
  - Address offsets: FIFOSPACE=4, LEFTDATA=8, RIGHTDATA=12.
  - Byte-enable constant 4'b1111.
- One sub-module, sample_fifo: synchronous FIFO, parameters W and DEPTH, ports push/pop/dout/count/full/empty.

Test Plan:
- Setup: rst pulse, enable=1, Avalon model acks after 2 cycles, read data 32'h7F7F0000. Push 18'sh00888 → writes to 0x3048 then 0x304C, data 32'h02220000 on both, one pop, fifo_space=8'h7F.
- Negative sample: push 18'sh3FFFF (−1) → both writes carry 32'hFFFFC000.
- Backpressure: read data 32'h40020000 (right space 2) → fifo_space=2, no writes, repeated polls. Changing to 32'h40400000 → writes resume.
- Underrun: space 0x7F, no pushes → underrun_count increments once per poll, bus_write never asserted. sample_req pulses exactly once until a push occurs.
- Timeout: model withholds ack on WR_L → after 1024 cycles bus_write drops, timeout_count=1. Next poll rewrites the same sample to both channels, and it is popped only after the WR_R ack.
- Async reset: assert rst mid-WR_R with 3 samples buffered → strobes 0 immediately, count 0, counters 0; after release the first bus action is a read of 0x3044.
